// File: rtl/kiwi_dbiu_axi_master.sv
// kiwi_dbiu_axi_master: LSU-to-AXI-lite bridge, one outstanding single-beat read or write.
// Rev 1.0
`default_nettype none

module kiwi_dbiu_axi_master #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    input  logic                  flush,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_W-1:0]     m_awaddr,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    output logic [ADDR_W-1:0]     m_araddr,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DATA_W-1:0]     m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rvalid,
    output logic                  m_rready
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_D = 3'd2,
        S_WR   = 3'd3,
        S_BRSP = 3'd4,
        S_RSP  = 3'd5
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic                drop;
    logic                aw_done;
    logic                w_done;

    logic accept;
    logic aw_now;
    logic w_now;

    assign accept = req_valid && req_ready;
    assign aw_now = aw_done || (m_awvalid && m_awready);
    assign w_now  = w_done  || (m_wvalid  && m_wready);

    assign m_araddr = addr_q;
    assign m_awaddr = addr_q;
    assign m_wdata  = wdata_q;
    assign m_wstrb  = wstrb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            req_ready <= 1'b0;
            m_arvalid <= 1'b0;
            m_rready  <= 1'b0;
            m_awvalid <= 1'b0;
            m_wvalid  <= 1'b0;
            m_bready  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            drop      <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
        end else begin
            // A flush marks the in-flight (or just-accepted) transaction's response for discard.
            if (flush && (state != S_IDLE || accept)) begin
                drop <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready <= 1'b0;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        wstrb_q   <= req_wstrb;
                        if (req_we) begin
                            m_awvalid <= 1'b1;
                            m_wvalid  <= 1'b1;
                            aw_done   <= 1'b0;
                            w_done    <= 1'b0;
                            state     <= S_WR;
                        end else begin
                            m_arvalid <= 1'b1;
                            state     <= S_RD_A;
                        end
                    end
                end
                S_RD_A: begin
                    if (m_arready) begin
                        m_arvalid <= 1'b0;
                        m_rready  <= 1'b1;
                        state     <= S_RD_D;
                    end
                end
                S_RD_D: begin
                    if (m_rvalid) begin
                        m_rready  <= 1'b0;
                        rsp_rdata <= m_rdata;
                        rsp_err   <= |m_rresp;
                        if (drop || flush) begin
                            drop      <= 1'b0;
                            req_ready <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            rsp_valid <= 1'b1;
                            state     <= S_RSP;
                        end
                    end
                end
                S_WR: begin
                    if (m_awvalid && m_awready) begin
                        m_awvalid <= 1'b0;
                    end
                    if (m_wvalid && m_wready) begin
                        m_wvalid <= 1'b0;
                    end
                    aw_done <= aw_now;
                    w_done  <= w_now;
                    if (aw_now && w_now) begin
                        m_bready <= 1'b1;
                        state    <= S_BRSP;
                    end
                end
                S_BRSP: begin
                    if (m_bvalid) begin
                        m_bready  <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= |m_bresp;
                        if (drop || flush) begin
                            drop      <= 1'b0;
                            req_ready <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            rsp_valid <= 1'b1;
                            state     <= S_RSP;
                        end
                    end
                end
                S_RSP: begin
                    if (rsp_ready || flush) begin
                        rsp_valid <= 1'b0;
                        drop      <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_kiwi_dbiu_axi_master.sv
// tb_kiwi_dbiu_axi_master: directed bench with a delay-configurable AXI-lite slave model.
// Rev 1.0
`default_nettype none

module tb_kiwi_dbiu_axi_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wstrb = '0;
    logic        flush = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic [63:0] m_awaddr;
    logic        m_awvalid;
    logic        m_awready;
    logic [63:0] m_wdata;
    logic [7:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;
    logic [63:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready;
    logic [63:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    kiwi_dbiu_axi_master #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .flush(flush),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    // AXI-lite slave model: each ready/valid appears after a programmable number of wait cycles.
    int          ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
    logic [1:0]  r_resp_cfg = 2'b00, b_resp_cfg = 2'b00;
    int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    logic        r_pend, b_pend, aw_got, w_got;
    logic [63:0] r_data_l, aw_addr_l, w_data_l;
    logic [7:0]  w_strb_l;
    logic [63:0] mem [0:31];

    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
    assign ar_hs = m_arvalid && m_arready;
    assign r_hs  = m_rvalid && m_rready;
    assign aw_hs = m_awvalid && m_awready;
    assign w_hs  = m_wvalid && m_wready;
    assign b_hs  = m_bvalid && m_bready;

    assign m_arready = m_arvalid && (ar_cnt >= ar_delay);
    assign m_rvalid  = r_pend && (r_cnt >= r_delay);
    assign m_rdata   = r_data_l;
    assign m_rresp   = r_resp_cfg;
    assign m_awready = m_awvalid && (aw_cnt >= aw_delay);
    assign m_wready  = m_wvalid && (w_cnt >= w_delay);
    assign m_bvalid  = b_pend && (b_cnt >= b_delay);
    assign m_bresp   = b_resp_cfg;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
            r_pend <= 1'b0; b_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
            r_data_l <= '0; aw_addr_l <= '0; w_data_l <= '0; w_strb_l <= '0;
            mem[0] <= 64'hDEAD_BEEF_0123_4567;
            mem[1] <= 64'h1111_2222_3333_4444;
        end else begin
            if (ar_hs) ar_cnt <= 0;
            else if (m_arvalid) ar_cnt <= ar_cnt + 1;
            if (ar_hs) begin
                r_pend   <= 1'b1;
                r_cnt    <= 0;
                r_data_l <= mem[m_araddr[7:3]];
            end else if (r_hs) begin
                r_pend <= 1'b0;
            end else if (r_pend) begin
                r_cnt <= r_cnt + 1;
            end
            if (aw_hs) aw_cnt <= 0;
            else if (m_awvalid) aw_cnt <= aw_cnt + 1;
            if (w_hs) w_cnt <= 0;
            else if (m_wvalid) w_cnt <= w_cnt + 1;
            if (aw_hs) begin aw_got <= 1'b1; aw_addr_l <= m_awaddr; end
            if (w_hs) begin w_got <= 1'b1; w_data_l <= m_wdata; w_strb_l <= m_wstrb; end
            if ((aw_got || aw_hs) && (w_got || w_hs) && !b_pend) begin
                for (int i = 0; i < 8; i++) begin
                    if (w_hs ? m_wstrb[i] : w_strb_l[i])
                        mem[aw_hs ? m_awaddr[7:3] : aw_addr_l[7:3]][i*8 +: 8] <=
                            w_hs ? m_wdata[i*8 +: 8] : w_data_l[i*8 +: 8];
                end
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                b_pend <= 1'b1;
                b_cnt  <= 0;
            end else if (b_hs) begin
                b_pend <= 1'b0;
            end else if (b_pend) begin
                b_cnt <= b_cnt + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns one cycle after the accepting edge.
    task automatic issue(input logic we, input logic [63:0] addr,
                         input logic [63:0] data, input logic [7:0] strb);
        int k = 0;
        while (!req_ready && k < 30) begin tick(); k++; end
        check("req_ready_before_issue", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data; req_wstrb = strb;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        int k = 0;
        while (!rsp_valid && k < 50) begin tick(); k++; end
        check(tag, {63'd0, rsp_valid}, 64'd1);
    endtask

    initial begin
        bit seen;
        // Reset state
        tick(); tick();
        check("rst_req_ready", {63'd0, req_ready}, 64'd0);
        check("rst_arvalid", {63'd0, m_arvalid}, 64'd0);
        check("rst_awvalid", {63'd0, m_awvalid}, 64'd0);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        rst = 1'b0;
        tick();
        check("post_rst_req_ready", {63'd0, req_ready}, 64'd1);

        // 1: zero-wait load, cycle-exact latency
        issue(1'b0, 64'h1000, '0, '0);
        check("t1_arvalid_n1", {63'd0, m_arvalid}, 64'd1);
        check("t1_araddr", m_araddr, 64'h1000);
        check("t1_req_ready_n1", {63'd0, req_ready}, 64'd0);
        tick();
        check("t1_rready_n2", {63'd0, m_rready}, 64'd1);
        check("t1_rvalid_n2", {63'd0, m_rvalid}, 64'd1);
        check("t1_arvalid_n2", {63'd0, m_arvalid}, 64'd0);
        tick();
        check("t1_rsp_valid_n3", {63'd0, rsp_valid}, 64'd1);
        check("t1_rdata", rsp_rdata, 64'hDEAD_BEEF_0123_4567);
        check("t1_err", {63'd0, rsp_err}, 64'd0);
        tick();
        check("t1_rsp_valid_n4", {63'd0, rsp_valid}, 64'd0);
        check("t1_req_ready_n4", {63'd0, req_ready}, 64'd1);

        // 2: store with AWREADY three cycles late
        aw_delay = 3;
        issue(1'b1, 64'h2008, 64'h55AA, 8'h0F);
        check("t2_awvalid_n1", {63'd0, m_awvalid}, 64'd1);
        check("t2_wvalid_n1", {63'd0, m_wvalid}, 64'd1);
        check("t2_wready_n1", {63'd0, m_wready}, 64'd1);
        check("t2_wstrb", {56'd0, m_wstrb}, 64'h0F);
        tick();
        check("t2_wvalid_n2", {63'd0, m_wvalid}, 64'd0);
        check("t2_awvalid_n2", {63'd0, m_awvalid}, 64'd1);
        check("t2_bready_n2", {63'd0, m_bready}, 64'd0);
        tick(); tick();
        check("t2_awready_n4", {63'd0, m_awready}, 64'd1);
        check("t2_awaddr", m_awaddr, 64'h2008);
        tick();
        check("t2_awvalid_n5", {63'd0, m_awvalid}, 64'd0);
        check("t2_bready_n5", {63'd0, m_bready}, 64'd1);
        tick();
        check("t2_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check("t2_err", {63'd0, rsp_err}, 64'd0);
        check("t2_rdata_zero", rsp_rdata, 64'd0);
        check("t2_mem", mem[1], 64'h1111_2222_0000_55AA);
        tick();
        aw_delay = 0;

        // 3: SLVERR on read, then a normal load
        r_resp_cfg = 2'b10;
        issue(1'b0, 64'h1000, '0, '0);
        wait_rsp("t3_rsp_timeout");
        check("t3_err", {63'd0, rsp_err}, 64'd1);
        tick();
        r_resp_cfg = 2'b00;
        issue(1'b0, 64'h2008, '0, '0);
        wait_rsp("t3b_rsp_timeout");
        check("t3b_rdata", rsp_rdata, 64'h1111_2222_0000_55AA);
        check("t3b_err", {63'd0, rsp_err}, 64'd0);
        tick();

        // 4: flush during a slow load drops the response
        r_delay = 5;
        issue(1'b0, 64'h1000, '0, '0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (rsp_valid) seen = 1'b1;
            if (m_rvalid && m_rready) break;
            tick();
        end
        check("t4_r_handshake", {63'd0, m_rvalid && m_rready}, 64'd1);
        tick();
        check("t4_req_ready", {63'd0, req_ready}, 64'd1);
        for (int k = 0; k < 3; k++) begin
            if (rsp_valid) seen = 1'b1;
            tick();
        end
        check("t4_no_rsp", {63'd0, seen}, 64'd0);
        r_delay = 0;

        // 5: response back-pressure
        rsp_ready = 1'b0;
        issue(1'b0, 64'h1000, '0, '0);
        wait_rsp("t5_rsp_timeout");
        for (int k = 0; k < 4; k++) begin
            check("t5_hold_valid", {63'd0, rsp_valid}, 64'd1);
            check("t5_hold_data", rsp_rdata, 64'hDEAD_BEEF_0123_4567);
            check("t5_req_ready_low", {63'd0, req_ready}, 64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("t5_released", {63'd0, rsp_valid}, 64'd0);

        // 6: async reset while AR is stalled
        ar_delay = 10;
        issue(1'b0, 64'h1000, '0, '0);
        tick();
        check("t6_arvalid_wait", {63'd0, m_arvalid}, 64'd1);
        rst = 1'b1;
        #1;
        check("t6_arvalid_async", {63'd0, m_arvalid}, 64'd0);
        check("t6_req_ready_rst", {63'd0, req_ready}, 64'd0);
        tick();
        rst = 1'b0;
        ar_delay = 0;
        tick();
        check("t6_req_ready_after", {63'd0, req_ready}, 64'd1);
        issue(1'b0, 64'h1000, '0, '0);
        wait_rsp("t6_rsp_timeout");
        check("t6_rdata", rsp_rdata, 64'hDEAD_BEEF_0123_4567);
        check("t6_err", {63'd0, rsp_err}, 64'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
